pulse2wb: RTL and testbench
===========================

Name: pulse2wb

Overview:
- Wishbone-readable pulse counter. It is the downstream consumer of the pulse generator's output and also takes external pulse trains.
- Synchronises an asynchronous pulse input and counts its rising edges over a programmable gate window.
- Captures each window's count into a read-only register.
- Lets firmware measure frequency and close the loop on the pulse generator through the same simple Wishbone slave handshake.

Parameters:
DSIZE, 8, data bus width; width of the gate-length, count and status registers.
PRESCALE, 10, clock cycles per gate tick (≥2); window length = gate_len × PRESCALE cycles.

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_stb  input  1  Wishbone strobe (cycle+strobe combined)
i_we   input  1  1 = write, 0 = read
i_adr  input  2  register select: 0 GATE, 1 COUNT, 2 STATUS, 3 reserved
i_dat  input  DSIZE  write data
i_e    input  1  measurement enable
i_pulse input 1  asynchronous pulse train to measure
o_ack  output 1  Wishbone acknowledge
o_dat  output DSIZE  read data
o_valid output 1  mirror of STATUS.valid, usable as interrupt

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_ack=0, o_dat=0, o_valid=0.
  - GATE=0, COUNT=0, STATUS=0; synchroniser flops, prescaler and counters cleared.
  - Reset mid-window discards the partial count.
- Handshake:
  - o_ack registered: o_ack <= i_stb & ~o_ack, so there is a one-cycle ack, 1 cycle after i_stb rises.
  - Master drops i_stb after ack. Held strobe yields ack every other cycle.
  - Register side effects occur only on the edge that sets o_ack.
- Reads:
  - o_dat is loaded on the ack edge and is 0 in every cycle o_ack=0.
  - GATE returns the stored value.
  - COUNT returns the captured count and clears STATUS.valid and STATUS.ovf.
  - STATUS returns {0…, ovf, valid} in bits [1:0].
  - Reserved address reads 0.
- Writes:
  - Only GATE is writable; writes to COUNT, STATUS and reserved are ignored (still acked).
  - A GATE write restarts the window: prescaler, tick counter and edge counter are cleared on the same edge.
- Input path:
  - 2-flop synchroniser plus a registered previous-value flop.
  - Rising edge is sync & ~prev; 3-cycle latency from an i_pulse edge to the count increment.
  - A pulse shorter than one clock may be missed; this is not an error.
- Window engine (active when i_e=1 and GATE≠0):
  - Prescaler counts 0..PRESCALE-1. Its wrap is a tick.
  - Tick counter counts ticks 0..GATE-1.
  - On the tick ending tick GATE-1:
    - COUNT <= edge counter value, including an edge detected on that same cycle.
    - Set STATUS.valid.
    - Set STATUS.ovf if the counter saturated.
    - Edge counter restarts at 0, the next window starts immediately, with no dead cycle.
- Edge counter width and saturation:
  - Edge counter is DSIZE+1 bits internally.
  - Saturates at 2^DSIZE−1 and sets an internal sat flag.
  - Captured value is saturated to DSIZE bits.
- Disable and capture collisions:
  - i_e=0 or GATE=0: prescaler, tick counter, edge counter and sat are held at 0. COUNT and STATUS are retained.
  - Re-enabling starts a fresh full window.
- Capture coinciding with a COUNT read:
  - Read returns the old COUNT.
  - The new capture wins: valid=1 afterwards, COUNT is new.
- Capture while valid is already 1 (unread):
  - COUNT is overwritten.
  - ovf is set.
  - ovf is sticky until the next COUNT read.
- o_valid = STATUS.valid, registered.

Decomposition:
- Shared package holds:
  - Address constants ADR_GATE=0, ADR_COUNT=1, ADR_STATUS=2.
  - Status bit indices ST_VALID=0, ST_OVF=1.
  - Shared with the pulse generator's register map constants.
- One sub-module, pulse_sync: synchroniser plus rising-edge detector.
  - Ports i_clk, i_rst, i_async, o_rise.
  - Reused by other asynchronous inputs in the SoC.

Test Plan:
- Reset, then read GATE, COUNT and STATUS at addresses 0,1,2 → each returns 0. o_ack is high exactly 1 cycle per access, one cycle after i_stb. o_valid=0.
- Write GATE=5, i_e=1, i_pulse with period 10 clocks → a capture every 50 cycles. Read COUNT → 5, STATUS.valid cleared. Next window captures 5 again.
- GATE=255, i_pulse period 2 clocks (1275 edges per window) → COUNT=255, STATUS=0b11. After a COUNT read, STATUS=0.
- GATE=3, pulse period 10, leave COUNT unread for two windows → STATUS.ovf=1, COUNT=3.
- Drop i_e mid-window for 100 cycles, then re-enable → no capture while disabled. The first capture arrives exactly 30 cycles after re-enable, and the old COUNT is retained meanwhile.
- Loopback from the pulse generator's o_pulse, and a GATE rewrite mid-window → window restarts on the write-ack edge. Assert i_rst mid-window → all registers 0 on the next edge.

Source files
------------

// File: rtl/pulse2wb_pkg.sv
// Register map shared by the pulse counter and the pulse generator.
// Address decode values and STATUS bit positions.
package pulse2wb_pkg;

  typedef enum logic [1:0] {
    ADR_GATE   = 2'd0,
    ADR_COUNT  = 2'd1,
    ADR_STATUS = 2'd2,
    ADR_RSVD   = 2'd3
  } adr_e;

  localparam int ST_VALID = 0;
  localparam int ST_OVF   = 1;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
// o_rise is high for one cycle per synchronised low-to-high transition.
module pulse_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/pulse2wb.sv
// Wishbone-readable gated pulse counter: counts synchronised rising edges over
// a window of GATE x PRESCALE cycles and captures each window's total into COUNT.
module pulse2wb
  import pulse2wb_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int PRESCALE = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [1:0]       i_adr,
  input  logic [DSIZE-1:0] i_dat,
  input  logic             i_e,
  input  logic             i_pulse,
  output logic             o_ack,
  output logic [DSIZE-1:0] o_dat,
  output logic             o_valid
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DSIZE:0] EDGE_MAX = {1'b0, {DSIZE{1'b1}}};

  logic rise;

  pulse_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pulse),
    .o_rise  (rise)
  );

  logic             ack_q, ack_d;
  logic [DSIZE-1:0] dat_q, dat_d;
  logic [DSIZE-1:0] gate_q, gate_d;
  logic [DSIZE-1:0] count_q, count_d;
  logic [1:0]       status_q, status_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DSIZE-1:0] tick_q, tick_d;
  logic [DSIZE:0]   edge_q, edge_d;
  logic             sat_q, sat_d;

  logic           access;
  logic           rd;
  logic           wr_gate;
  logic           rd_count;
  logic           active;
  logic           tick;
  logic           last_tick;
  logic           capture;
  logic [DSIZE:0] edge_sum;
  logic           edge_ovf;

  assign access    = i_stb & ~ack_q;
  assign rd        = access & ~i_we;
  assign wr_gate   = access & i_we & (i_adr == ADR_GATE);
  assign rd_count  = rd & (i_adr == ADR_COUNT);
  assign active    = i_e & (gate_q != '0);
  assign tick      = (presc_q == PW'(PRESCALE - 1));
  assign last_tick = (tick_q == gate_q - DSIZE'(1));
  // A GATE write restarts the window, so it also suppresses a capture on that edge.
  assign capture   = active & ~wr_gate & tick & last_tick;
  assign edge_sum  = edge_q + {{DSIZE{1'b0}}, rise};
  assign edge_ovf  = (edge_sum > EDGE_MAX);

  always_comb begin
    ack_d    = access;
    dat_d    = '0;
    gate_d   = gate_q;
    count_d  = count_q;
    status_d = status_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    edge_d   = edge_q;
    sat_d    = sat_q;

    if (rd) begin
      case (adr_e'(i_adr))
        ADR_GATE:   dat_d = gate_q;
        ADR_COUNT:  dat_d = count_q;
        ADR_STATUS: dat_d = DSIZE'(status_q);
        default:    dat_d = '0;
      endcase
    end

    if (wr_gate) gate_d = i_dat;
    if (rd_count) status_d = '0;

    if (wr_gate || !active) begin
      presc_d = '0;
      tick_d  = '0;
      edge_d  = '0;
      sat_d   = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (capture) begin
        // Capture takes the edge seen this cycle; ovf also flags an unread COUNT.
        count_d            = edge_ovf ? EDGE_MAX[DSIZE-1:0] : edge_sum[DSIZE-1:0];
        status_d[ST_OVF]   = status_d[ST_OVF] | status_d[ST_VALID] | sat_q | edge_ovf;
        status_d[ST_VALID] = 1'b1;
        tick_d             = '0;
        edge_d             = '0;
        sat_d              = 1'b0;
      end else begin
        tick_d = tick ? tick_q + DSIZE'(1) : tick_q;
        edge_d = edge_ovf ? EDGE_MAX : edge_sum;
        sat_d  = sat_q | edge_ovf;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      gate_q   <= '0;
      count_q  <= '0;
      status_q <= '0;
      presc_q  <= '0;
      tick_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      gate_q   <= gate_d;
      count_q  <= count_d;
      status_q <= status_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      edge_q   <= edge_d;
      sat_q    <= sat_d;
    end
  end

  assign o_ack   = ack_q;
  assign o_dat   = dat_q;
  assign o_valid = status_q[ST_VALID];

endmodule

// File: tb/tb_pulse2wb.sv
// Scoreboard bench for pulse2wb: bus accesses queue their expected read data,
// a negedge monitor pops and checks on every acknowledge.
module tb_pulse2wb;

  localparam int DSIZE    = 8;
  localparam int PRESCALE = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stb = 1'b0;
  logic             we  = 1'b0;
  logic [1:0]       adr = '0;
  logic [DSIZE-1:0] datIn = '0;
  logic             enable = 1'b0;
  logic             pulse = 1'b0;
  logic             ack;
  logic [DSIZE-1:0] datOut;
  logic             valid;

  int assertCount = 0;
  int failCount   = 0;
  int period      = 0;
  int phase       = 0;

  logic [DSIZE:0] sbQueue[$];
  logic [DSIZE:0] sbEntry;

  pulse2wb #(.DSIZE(DSIZE), .PRESCALE(PRESCALE)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_stb   (stb),
    .i_we    (we),
    .i_adr   (adr),
    .i_dat   (datIn),
    .i_e     (enable),
    .i_pulse (pulse),
    .o_ack   (ack),
    .o_dat   (datOut),
    .o_valid (valid)
  );

  always #5 clk = ~clk;

  // Pulse source: high for period/2 cycles of every period, changed off the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (period == 0) begin
        pulse = 1'b0;
        phase = 0;
      end else begin
        pulse = (phase < period / 2);
        phase = (phase + 1 >= period) ? 0 : phase + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One bus access; reads push their expected data, writes expect o_dat=0.
  task automatic applyStimulus(input logic wr, input logic [1:0] a, input logic [DSIZE-1:0] d,
                               input logic [DSIZE-1:0] expRead);
    @(posedge clk);
    #1;
    checkOutput("ackIdle", {31'b0, ack}, 32'd0);
    stb   = 1'b1;
    we    = wr;
    adr   = a;
    datIn = d;
    sbQueue.push_back({~wr, wr ? {DSIZE{1'b0}} : expRead});
    @(posedge clk);
    #1;
    checkOutput("ackLatency", {31'b0, ack}, 32'd1);
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic cyclesToValid(input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedAck", 32'd1, 32'd0);
      end else begin
        sbEntry = sbQueue.pop_front();
        if (sbEntry[DSIZE])
          checkOutput($sformatf("readData adr=%0d", adr), {24'b0, datOut}, {24'b0, sbEntry[DSIZE-1:0]});
        else
          checkOutput("writeAckData", {24'b0, datOut}, 32'd0);
      end
    end else begin
      checkOutput("datIdle", {24'b0, datOut}, 32'd0);
    end
  end

  initial begin
    int n;
    bit sawValid;

    $display("[TB] reset and idle reads");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetValid", {31'b0, valid}, 32'd0);
    applyStimulus(1'b0, 2'd0, '0, 8'd0);
    applyStimulus(1'b0, 2'd1, '0, 8'd0);
    applyStimulus(1'b0, 2'd2, '0, 8'd0);
    applyStimulus(1'b0, 2'd3, '0, 8'd0);

    $display("[TB] GATE=5, period 10");
    enable = 1'b1;
    period = 10;
    repeat (20) @(posedge clk);
    applyStimulus(1'b1, 2'd0, 8'd5, '0);
    cyclesToValid(200, n);
    checkOutput("gate5Latency", n, 32'd50);
    applyStimulus(1'b1, 2'd1, 8'h77, '0);
    applyStimulus(1'b1, 2'd3, 8'h3c, '0);
    applyStimulus(1'b0, 2'd2, '0, 8'd1);
    applyStimulus(1'b0, 2'd1, '0, 8'd5);
    applyStimulus(1'b0, 2'd2, '0, 8'd0);
    applyStimulus(1'b0, 2'd0, '0, 8'd5);
    cyclesToValid(200, n);
    checkOutput("gate5SecondValid", {31'b0, valid}, 32'd1);
    applyStimulus(1'b0, 2'd1, '0, 8'd5);

    $display("[TB] GATE=255, period 2 saturation");
    period = 2;
    repeat (12) @(posedge clk);
    applyStimulus(1'b1, 2'd0, 8'd255, '0);
    cyclesToValid(3000, n);
    checkOutput("satLatency", n, 32'd2550);
    applyStimulus(1'b0, 2'd2, '0, 8'd3);
    applyStimulus(1'b0, 2'd1, '0, 8'd255);
    applyStimulus(1'b0, 2'd2, '0, 8'd0);
    checkOutput("satValidCleared", {31'b0, valid}, 32'd0);

    $display("[TB] GATE=3, unread overwrite");
    period = 10;
    repeat (20) @(posedge clk);
    applyStimulus(1'b1, 2'd0, 8'd3, '0);
    cyclesToValid(200, n);
    checkOutput("gate3Latency", n, 32'd30);
    repeat (40) @(posedge clk);
    applyStimulus(1'b0, 2'd2, '0, 8'd3);
    applyStimulus(1'b0, 2'd1, '0, 8'd3);
    applyStimulus(1'b0, 2'd2, '0, 8'd0);

    $display("[TB] disable mid-window");
    cyclesToValid(200, n);
    checkOutput("gate3NextValid", {31'b0, valid}, 32'd1);
    applyStimulus(1'b0, 2'd1, '0, 8'd3);
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid) sawValid = 1'b1;
      if (i == 50) applyStimulus(1'b0, 2'd1, '0, 8'd3);
    end
    checkOutput("noCaptureDisabled", {31'b0, sawValid}, 32'd0);
    enable = 1'b1;
    cyclesToValid(200, n);
    checkOutput("reenableLatency", n, 32'd30);
    applyStimulus(1'b0, 2'd1, '0, 8'd3);

    $display("[TB] GATE rewrite mid-window");
    repeat (15) @(posedge clk);
    applyStimulus(1'b1, 2'd0, 8'd4, '0);
    cyclesToValid(200, n);
    checkOutput("rewriteLatency", n, 32'd40);
    applyStimulus(1'b0, 2'd0, '0, 8'd4);
    applyStimulus(1'b0, 2'd2, '0, 8'd1);

    $display("[TB] reset mid-window");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midResetValid", {31'b0, valid}, 32'd0);
    checkOutput("midResetAck", {31'b0, ack}, 32'd0);
    applyStimulus(1'b0, 2'd0, '0, 8'd0);
    applyStimulus(1'b0, 2'd1, '0, 8'd0);
    applyStimulus(1'b0, 2'd2, '0, 8'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", sbQueue.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
